// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the uart_tx/uart_rx/parser family.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    CMD     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4
  } parser_state_e;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } frame_err_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap watchdog: counts idle cycles while enabled, pulses expire at the limit.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 34720
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  // A clear in the expiry cycle suppresses the pulse, so an arriving byte always wins.
  assign expire = enable && !clear && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || clear || expire) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Host command frame parser: SYNC, LEN, CMD, LEN*4 payload bytes (LSB first), XOR checksum.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_WORDS     = 16,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int IDX_W = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [31:0]      word_data,
  output logic [IDX_W-1:0] word_idx,
  output logic             word_valid,
  output logic [7:0]       frame_cmd,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned CLKS_PER_BIT   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_LEN     = LEN;
  localparam logic [2:0] S_CMD     = CMD;
  localparam logic [2:0] S_PAYLOAD = PAYLOAD;
  localparam logic [2:0] S_CHK     = CHK;

  logic [2:0]       state_reg;
  logic [7:0]       acc_reg;
  logic [IDX_W:0]   len_reg;
  logic [7:0]       cmd_shadow_reg;
  logic [1:0]       byte_cnt_reg;
  logic [IDX_W-1:0] word_cnt_reg;
  logic [31:0]      word_shift_reg;
  logic [31:0]      word_data_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic             word_valid_reg;
  logic [7:0]       frame_cmd_reg;
  logic             frame_done_reg;
  logic             frame_err_reg;
  logic [1:0]       err_code_reg;
  logic [7:0]       drop_cnt_reg;
  logic             gap_expire;
  logic             last_word;

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_reg != S_IDLE),
    .clear  (rx_valid),
    .expire (gap_expire)
  );

  assign last_word = (word_cnt_reg == IDX_W'(len_reg - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      acc_reg        <= '0;
      len_reg        <= '0;
      cmd_shadow_reg <= '0;
      byte_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
      word_shift_reg <= '0;
      word_data_reg  <= '0;
      word_idx_reg   <= '0;
      word_valid_reg <= 1'b0;
      frame_cmd_reg  <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_code_reg   <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      // Counters are zero whenever a frame starts.
      if (state_reg == S_IDLE) begin
        byte_cnt_reg <= '0;
        word_cnt_reg <= '0;
      end
      if (gap_expire) begin
        frame_err_reg <= 1'b1;
        err_code_reg  <= ERR_TIMEOUT;
        state_reg     <= S_IDLE;
      end else if (rx_valid) begin
        case (state_reg)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              acc_reg   <= '0;
              state_reg <= S_LEN;
            end else if (drop_cnt_reg != 8'hFF) begin
              drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
          end
          S_LEN: begin
            if (rx_data == 8'd0 || rx_data > 8'(MAX_WORDS)) begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= ERR_LEN;
              state_reg     <= S_IDLE;
            end else begin
              len_reg   <= rx_data[IDX_W:0];
              acc_reg   <= rx_data;
              state_reg <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_shadow_reg <= rx_data;
            acc_reg        <= acc_reg ^ rx_data;
            state_reg      <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            word_shift_reg[{byte_cnt_reg, 3'b000} +: 8] <= rx_data;
            acc_reg      <= acc_reg ^ rx_data;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == 2'd3) begin
              word_data_reg  <= {rx_data, word_shift_reg[23:0]};
              word_idx_reg   <= word_cnt_reg;
              word_valid_reg <= 1'b1;
              word_cnt_reg   <= word_cnt_reg + 1'b1;
              if (last_word) begin
                state_reg <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (rx_data == acc_reg) begin
              frame_cmd_reg  <= cmd_shadow_reg;
              frame_done_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= ERR_CHK;
            end
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign word_data  = word_data_reg;
  assign word_idx   = word_idx_reg;
  assign word_valid = word_valid_reg;
  assign frame_cmd  = frame_cmd_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: bytes are driven straight onto rx_data/rx_valid.
module tb_uart_rx_frame_parser;

  localparam int unsigned CLK_HZ  = 11_520_000;
  localparam int unsigned BAUD    = 115200;
  localparam int unsigned TOUT_B  = 4;
  localparam int unsigned T_CYC   = TOUT_B * 10 * (CLK_HZ / BAUD);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] word_data;
  logic [3:0]  word_idx;
  logic        word_valid;
  logic [7:0]  frame_cmd;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  int          wcount = 0;
  logic [31:0] wlog_data [0:31];
  logic [3:0]  wlog_idx  [0:31];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_frame_parser #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .BAUD_RATE    (BAUD),
    .SYNC_BYTE    (8'hA5),
    .MAX_WORDS    (16),
    .TIMEOUT_BYTES(TOUT_B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .word_data (word_data),
    .word_idx  (word_idx),
    .word_valid(word_valid),
    .frame_cmd (frame_cmd),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  always @(negedge clk) begin
    if (word_valid === 1'b1 && wcount < 32) begin
      wlog_data[wcount] = word_data;
      wlog_idx[wcount]  = word_idx;
      wcount++;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic send_head(input logic [7:0] len, input logic [7:0] cmd);
    send_byte(8'hA5);
    send_byte(len);
    send_byte(cmd);
  endtask

  // Sends the 4 bytes of 0x12345678 LSB first; the word pulse is checked on the last one.
  task automatic send_word_12345678(input string tag);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    check({tag, "_wv"}, {31'd0, word_valid}, 32'd1);
    check({tag, "_wd"}, word_data, 32'h12345678);
    check({tag, "_wi"}, {28'd0, word_idx}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [0:15];
    logic [7:0]  chk;
    int          n;
    int          errs_before;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_word_data", word_data, 32'd0);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_frame_cmd", {24'd0, frame_cmd}, 32'd0);
    check("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;

    // Good frame A5 01 10 78 56 34 12 19
    send_head(8'h01, 8'h10);
    send_word_12345678("good");
    send_byte(8'h19);
    check("good_done", {31'd0, frame_done}, 32'd1);
    check("good_err", {31'd0, frame_err}, 32'd0);
    check("good_cmd", {24'd0, frame_cmd}, 32'h10);
    @(negedge clk); #1;
    check("good_done_pulse", {31'd0, frame_done}, 32'd0);

    // Bad checksum, CMD 0x22 (correct CHK would be 0x2B)
    send_head(8'h01, 8'h22);
    send_word_12345678("badchk");
    send_byte(8'h2A);
    check("badchk_err", {31'd0, frame_err}, 32'd1);
    check("badchk_done", {31'd0, frame_done}, 32'd0);
    check("badchk_code", {30'd0, err_code}, 32'd1);
    check("badchk_cmd_held", {24'd0, frame_cmd}, 32'h10);

    // LEN out of range
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len0_err", {31'd0, frame_err}, 32'd1);
    check("len0_code", {30'd0, err_code}, 32'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    check("len17_err", {31'd0, frame_err}, 32'd1);
    check("len17_code", {30'd0, err_code}, 32'd0);
    // Good frame CMD 0x33, CHK 0x3A
    send_head(8'h01, 8'h33);
    send_word_12345678("afterlen");
    send_byte(8'h3A);
    check("afterlen_done", {31'd0, frame_done}, 32'd1);
    check("afterlen_cmd", {24'd0, frame_cmd}, 32'h33);
    check("drop_none", {24'd0, drop_cnt}, 32'd0);

    // Timeout after a partial payload
    send_head(8'h01, 8'h10);
    send_byte(8'h78);
    send_byte(8'h56);
    n = 0;
    while (frame_err !== 1'b1 && n < int'(T_CYC) + 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("tout_cycles", n, T_CYC);
    check("tout_code", {30'd0, err_code}, 32'd2);

    // Byte in the expiry cycle wins
    errs_before = err_cnt;
    send_head(8'h01, 8'h10);
    send_byte(8'h78);
    send_byte(8'h56);
    repeat (T_CYC - 2) @(negedge clk);
    #1;
    send_byte(8'h34);
    check("tout_suppressed", {31'd0, frame_err}, 32'd0);
    send_byte(8'h12);
    check("tout_late_wv", {31'd0, word_valid}, 32'd1);
    send_byte(8'h19);
    check("tout_late_done", {31'd0, frame_done}, 32'd1);
    check("tout_no_err", err_cnt, errs_before);

    // Leading garbage then a good frame
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("drop_3", {24'd0, drop_cnt}, 32'd3);
    send_head(8'h01, 8'h10);
    send_word_12345678("garbage");
    send_byte(8'h19);
    check("garbage_done", {31'd0, frame_done}, 32'd1);
    for (int i = 0; i < 251; i++) send_byte(8'h00);
    check("drop_254", {24'd0, drop_cnt}, 32'd254);
    for (int i = 0; i < 49; i++) send_byte(8'h3C);
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);

    // 16-word frame, CMD 0x44, word 3 made of SYNC bytes
    chk = 8'h10 ^ 8'h44;
    for (int i = 0; i < 16; i++) begin
      words[i] = {8'(i), 8'(8'h30 + i), 8'(8'h60 + i), 8'(8'h90 + i)};
      if (i == 3) words[i] = 32'hA5A5A5A5;
      chk = chk ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    end
    wcount = 0;
    send_head(8'h10, 8'h44);
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8]);
    send_byte(chk);
    check("multi_done", {31'd0, frame_done}, 32'd1);
    check("multi_cmd", {24'd0, frame_cmd}, 32'h44);
    check("multi_count", wcount, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("multi_idx%0d", i), {28'd0, wlog_idx[i]}, i);
      check($sformatf("multi_data%0d", i), wlog_data[i], words[i]);
    end

    // Reset in the middle of a repeat frame
    errs_before = err_cnt;
    n = done_cnt;
    send_head(8'h10, 8'h44);
    for (int b = 0; b < 6; b++) send_byte(words[0][8*(b%4) +: 8]);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_cmd", {24'd0, frame_cmd}, 32'd0);
    check("midrst_word", word_data, 32'd0);
    check("midrst_drop", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_err", err_cnt, errs_before);
    check("midrst_no_done", done_cnt, n);
    send_head(8'h01, 8'h10);
    send_word_12345678("postrst");
    send_byte(8'h19);
    check("postrst_done", {31'd0, frame_done}, 32'd1);
    check("postrst_cmd", {24'd0, frame_cmd}, 32'h10);
    check("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
